hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised hazard and forwarding unit for the 5-stage MIPS pipeline, replacing the stall-only compare logic inside the datapath's ID stage. It keeps a shift-register scoreboard of in-flight register writes, one entry per stage after ID. It forwards operands from the stage that holds a ready result, and stalls ID only when a result is not yet available, such as a load-use hazard. It also applies flush and global hold, and keeps stall and forward performance counters.

Parameters:
DATA_W, 32, operand/result width
ADDR_W, 5, register address width
DEPTH, 3, tracked stages after ID (entry 1 = EXE, 2 = MEM, 3 = WB)
FWD_EN, 1, 1 = forward when possible; 0 = stall on any match (stall-only mode)
FLUSH_N, 1, number of youngest entries cleared by flush (1..DEPTH)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
id_valid  in  1  ID holds a real instruction
rs_used  in  1  ID reads rs
rt_used  in  1  ID reads rt
addr_rs  in  ADDR_W  ID rs address
addr_rt  in  ADDR_W  ID rt address
id_wen  in  1  ID instruction writes a register
id_waddr  in  ADDR_W  ID destination register
id_rdy_stage  in  2  first entry index whose stage_data holds this instruction's result (1 = ALU, 2 = load)
data_rs  in  DATA_W  regfile rs read data
data_rt  in  DATA_W  regfile rt read data
stage_data  in  DEPTH*DATA_W  result bus; slice [i*DATA_W +: DATA_W] is the result of entry i+1
hold  in  1  global freeze (memory wait); scoreboard does not shift
flush  in  1  branch taken; kill the youngest instructions
opa_fwd  out  DATA_W  resolved rs operand
opb_fwd  out  DATA_W  resolved rt operand
fwd_a_src  out  2  0 = regfile, i = entry i (DEPTH <= 3)
fwd_b_src  out  2  as fwd_a_src, for rt
reg_stall  out  1  ID must hold and a bubble is inserted
stall_cnt  out  32  cycles with reg_stall=1 and hold=0, saturating
fwd_cnt  out  32  issued instructions that used at least one forwarded operand, saturating

Behaviour:
- Each entry i holds {v, wen, waddr, rdy}. An entry matches an operand when v & wen & waddr == addr & addr != 0 & the corresponding *_used is set.
- Operand resolve (combinational):
  - Take the youngest matching entry (smallest i).
  - If there is no match: operand = regfile data, src = 0.
  - If there is a match, FWD_EN=1 and i >= rdy: operand = stage_data slice i, src = i.
  - Otherwise the operand is unresolved.
- reg_stall = id_valid & (rs unresolved | rt unresolved). With FWD_EN=0, every match is unresolved.
- The younger-entry match has priority even if it is not ready. In that case the unit stalls; it never uses an older stale value.
- Clock edge, priority order:
  - rst: all entries cleared, counters 0.
  - hold=1: no change to entries or counters. A flush arriving with hold=1 is ignored, so the owner keeps flush asserted until hold drops.
  - flush=1: shift as normal, then clear v of entries 1..FLUSH_N, including the incoming one.
  - Normal: entry i+1 <= entry i for i=1..DEPTH-1. Entry 1 <= {id_valid & ~reg_stall, id_wen, id_waddr, id_rdy_stage}. The WB entry falls off the end.
- A stall inserts a bubble (v=0) into entry 1, while older entries keep shifting so the hazard clears.
- Counters increment only when hold=0 and flush=0. Both saturate at 32'hFFFF_FFFF.
- Reset values: all v=0, so reg_stall=0, fwd_*_src=0, opa_fwd=data_rs, opb_fwd=data_rt, stall_cnt=0, fwd_cnt=0.
- Reset is asynchronous. When asserted mid-stall, reg_stall drops in the same cycle.
- Writes to register 0 never match. id_rdy_stage > DEPTH means the result is never forwardable, so the unit stalls until the entry retires.
- Latency: resolve and stall are 0-cycle combinational from inputs and state. The scoreboard updates 1 cycle after issue.

Test Plan:
- ADD r3 issued (rdy=1), next cycle SUB uses rs=r3 -> reg_stall=0, fwd_a_src=1, opa_fwd=stage_data entry1, fwd_cnt=1.
- LW r4 (rdy=2), next cycle uses rt=r4:
  - cycle 1: reg_stall=1, bubble inserted into entry 1, stall_cnt=1.
  - cycle 2: fwd_b_src=2, opb_fwd=MEM slice, reg_stall=0.
- Same sequences with FWD_EN=0 -> ADD dependency stalls 3 cycles and LW dependency stalls 3 cycles; fwd_a_src stays 0 throughout.
- ADD r5 then LW r5 back-to-back, then a consumer of r5 -> youngest entry (the LW, not ready) wins: reg_stall=1, never forwards the ADD value.
- Dependent pair with hold=1 for 4 cycles -> entries frozen, reg_stall constant, stall_cnt unchanged; resumes exactly when hold drops.
- flush with FLUSH_N=2 while LW r6 is in entry 1 and a consumer is in ID -> next cycle entries 1-2 invalid, no stall on r6; rst mid-stall -> reg_stall=0 immediately; counter preloaded to max stays 32'hFFFF_FFFF.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding unit: shift-register scoreboard of in-flight writes,
// per-operand forward-or-stall resolve, flush/hold handling, perf counters.
module hazard_scoreboard #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int DEPTH   = 3,
   parameter int FWD_EN  = 1,
   parameter int FLUSH_N = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    id_valid,
   input  logic                    rs_used,
   input  logic                    rt_used,
   input  logic [ADDR_W-1:0]       addr_rs,
   input  logic [ADDR_W-1:0]       addr_rt,
   input  logic                    id_wen,
   input  logic [ADDR_W-1:0]       id_waddr,
   input  logic [1:0]              id_rdy_stage,
   input  logic [DATA_W-1:0]       data_rs,
   input  logic [DATA_W-1:0]       data_rt,
   input  logic [DEPTH*DATA_W-1:0] stage_data,
   input  logic                    hold,
   input  logic                    flush,
   output logic [DATA_W-1:0]       opa_fwd,
   output logic [DATA_W-1:0]       opb_fwd,
   output logic [1:0]              fwd_a_src,
   output logic [1:0]              fwd_b_src,
   output logic                    reg_stall,
   output logic [31:0]             stall_cnt,
   output logic [31:0]             fwd_cnt
);

   logic [DEPTH-1:0]  v_q, v_d;
   logic [DEPTH-1:0]  wen_q, wen_d;
   logic [ADDR_W-1:0] waddr_q [DEPTH];
   logic [ADDR_W-1:0] waddr_d [DEPTH];
   logic [1:0]        rdy_q [DEPTH];
   logic [1:0]        rdy_d [DEPTH];
   logic [31:0]       stall_cnt_q, stall_cnt_d;
   logic [31:0]       fwd_cnt_q, fwd_cnt_d;

   logic [ADDR_W-1:0] op_addr [2];
   logic              op_used [2];
   logic [1:0]        op_src [2];
   logic              op_unres [2];
   logic              issue;

   // Scan oldest to youngest so the youngest match ends up winning.
   always_comb begin
      op_addr[0] = addr_rs;
      op_addr[1] = addr_rt;
      op_used[0] = rs_used;
      op_used[1] = rt_used;
      for (int k = 0; k < 2; k++) begin
         int  idx;
         logic hit;
         idx         = 0;
         hit         = 1'b0;
         op_src[k]   = 2'd0;
         op_unres[k] = 1'b0;
         for (int i = DEPTH - 1; i >= 0; i--) begin
            if (v_q[i] && wen_q[i] && op_used[k] &&
                waddr_q[i] == op_addr[k] && op_addr[k] != '0) begin
               hit = 1'b1;
               idx = i;
            end
         end
         if (hit) begin
            if (FWD_EN != 0 && idx + 1 >= int'(rdy_q[idx]))
               op_src[k] = 2'(idx + 1);
            else
               op_unres[k] = 1'b1;
         end
      end
   end

   always_comb begin
      fwd_a_src = op_src[0];
      fwd_b_src = op_src[1];
      opa_fwd   = data_rs;
      opb_fwd   = data_rt;
      if (op_src[0] != 2'd0)
         opa_fwd = stage_data[(int'(op_src[0]) - 1) * DATA_W +: DATA_W];
      if (op_src[1] != 2'd0)
         opb_fwd = stage_data[(int'(op_src[1]) - 1) * DATA_W +: DATA_W];
      reg_stall = id_valid & (op_unres[0] | op_unres[1]);
      issue     = id_valid & ~reg_stall;
   end

   always_comb begin
      v_d         = v_q;
      wen_d       = wen_q;
      waddr_d     = waddr_q;
      rdy_d       = rdy_q;
      stall_cnt_d = stall_cnt_q;
      fwd_cnt_d   = fwd_cnt_q;
      if (!hold) begin
         for (int i = DEPTH - 1; i >= 1; i--) begin
            v_d[i]     = v_q[i-1];
            wen_d[i]   = wen_q[i-1];
            waddr_d[i] = waddr_q[i-1];
            rdy_d[i]   = rdy_q[i-1];
         end
         v_d[0]     = issue;
         wen_d[0]   = id_wen;
         waddr_d[0] = id_waddr;
         rdy_d[0]   = id_rdy_stage;
         if (flush) begin
            for (int i = 0; i < FLUSH_N; i++)
               v_d[i] = 1'b0;
         end else begin
            if (reg_stall && stall_cnt_q != 32'hFFFF_FFFF)
               stall_cnt_d = stall_cnt_q + 32'd1;
            if (issue && (op_src[0] != 2'd0 || op_src[1] != 2'd0) &&
                fwd_cnt_q != 32'hFFFF_FFFF)
               fwd_cnt_d = fwd_cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q         <= '0;
         wen_q       <= '0;
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            waddr_q[i] <= '0;
            rdy_q[i]   <= '0;
         end
      end else begin
         v_q         <= v_d;
         wen_q       <= wen_d;
         waddr_q     <= waddr_d;
         rdy_q       <= rdy_d;
         stall_cnt_q <= stall_cnt_d;
         fwd_cnt_q   <= fwd_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign fwd_cnt   = fwd_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding, stall-only and
// flush-depth variants driven by one shared stimulus.
module tb_hazard_scoreboard;

   localparam logic [31:0] E1 = 32'h1111_1111;
   localparam logic [31:0] E2 = 32'h2222_2222;
   localparam logic [31:0] E3 = 32'h3333_3333;
   localparam logic [31:0] RS = 32'hAAAA_AAAA;
   localparam logic [31:0] RT = 32'hBBBB_BBBB;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_valid = 1'b0, rs_used = 1'b0, rt_used = 1'b0;
   logic [4:0]  addr_rs = '0, addr_rt = '0, id_waddr = '0;
   logic        id_wen = 1'b0;
   logic [1:0]  id_rdy_stage = '0;
   logic [31:0] data_rs = RS, data_rt = RT;
   logic [95:0] stage_data = {E3, E2, E1};
   logic        hold = 1'b0, flush = 1'b0;

   logic [31:0] a_f, b_f, sc_f, fc_f;
   logic [1:0]  as_f, bs_f;
   logic        st_f;
   logic [31:0] a_n, b_n, sc_n, fc_n;
   logic [1:0]  as_n, bs_n;
   logic        st_n;
   logic [31:0] a_2, b_2, sc_2, fc_2;
   logic [1:0]  as_2, bs_2;
   logic        st_2;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   hazard_scoreboard u_fwd (
      .clk(clk), .rst(rst), .id_valid(id_valid), .rs_used(rs_used),
      .rt_used(rt_used), .addr_rs(addr_rs), .addr_rt(addr_rt),
      .id_wen(id_wen), .id_waddr(id_waddr), .id_rdy_stage(id_rdy_stage),
      .data_rs(data_rs), .data_rt(data_rt), .stage_data(stage_data),
      .hold(hold), .flush(flush), .opa_fwd(a_f), .opb_fwd(b_f),
      .fwd_a_src(as_f), .fwd_b_src(bs_f), .reg_stall(st_f),
      .stall_cnt(sc_f), .fwd_cnt(fc_f));

   hazard_scoreboard #(.FWD_EN(0)) u_nf (
      .clk(clk), .rst(rst), .id_valid(id_valid), .rs_used(rs_used),
      .rt_used(rt_used), .addr_rs(addr_rs), .addr_rt(addr_rt),
      .id_wen(id_wen), .id_waddr(id_waddr), .id_rdy_stage(id_rdy_stage),
      .data_rs(data_rs), .data_rt(data_rt), .stage_data(stage_data),
      .hold(hold), .flush(flush), .opa_fwd(a_n), .opb_fwd(b_n),
      .fwd_a_src(as_n), .fwd_b_src(bs_n), .reg_stall(st_n),
      .stall_cnt(sc_n), .fwd_cnt(fc_n));

   hazard_scoreboard #(.FLUSH_N(2)) u_f2 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .rs_used(rs_used),
      .rt_used(rt_used), .addr_rs(addr_rs), .addr_rt(addr_rt),
      .id_wen(id_wen), .id_waddr(id_waddr), .id_rdy_stage(id_rdy_stage),
      .data_rs(data_rs), .data_rt(data_rt), .stage_data(stage_data),
      .hold(hold), .flush(flush), .opa_fwd(a_2), .opb_fwd(b_2),
      .fwd_a_src(as_2), .fwd_b_src(bs_2), .reg_stall(st_2),
      .stall_cnt(sc_2), .fwd_cnt(fc_2));

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_id(input logic v, input logic ru, input logic [4:0] ra,
                         input logic tu, input logic [4:0] ta,
                         input logic w, input logic [4:0] wa,
                         input logic [1:0] rdy);
      id_valid = v; rs_used = ru; addr_rs = ra; rt_used = tu;
      addr_rt = ta; id_wen = w; id_waddr = wa; id_rdy_stage = rdy;
   endtask

   task automatic do_reset;
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      hold = 1'b0; flush = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      do_reset();
      #1;
      chk("rst_stall", 32'(st_f), 0);
      chk("rst_srca", 32'(as_f), 0);
      chk("rst_srcb", 32'(bs_f), 0);
      chk("rst_opa", a_f, RS);
      chk("rst_opb", b_f, RT);
      chk("rst_scnt", sc_f, 0);
      chk("rst_fcnt", fc_f, 0);

      // ADD r3 then SUB rs=r3: forwarded from EXE
      do_reset();
      set_id(1, 0, 0, 0, 0, 1, 3, 1); tick();
      set_id(1, 1, 3, 0, 0, 1, 7, 1); #1;
      chk("add_stall", 32'(st_f), 0);
      chk("add_srca", 32'(as_f), 1);
      chk("add_opa", a_f, E1);
      chk("add_srcb", 32'(bs_f), 0);
      tick(); set_id(0, 0, 0, 0, 0, 0, 0, 0); #1;
      chk("add_fcnt", fc_f, 1);
      chk("add_scnt", sc_f, 0);

      // LW r4 then consumer rt=r4: one bubble then MEM forward
      do_reset();
      set_id(1, 0, 0, 0, 0, 1, 4, 2); tick();
      set_id(1, 0, 0, 1, 4, 1, 8, 1); #1;
      chk("lw_stall1", 32'(st_f), 1);
      tick(); #1;
      chk("lw_scnt", sc_f, 1);
      chk("lw_stall2", 32'(st_f), 0);
      chk("lw_srcb", 32'(bs_f), 2);
      chk("lw_opb", b_f, E2);

      // ADD r5, LW r5, consumer: younger LW wins
      do_reset();
      set_id(1, 0, 0, 0, 0, 1, 5, 1); tick();
      set_id(1, 0, 0, 0, 0, 1, 5, 2); tick();
      set_id(1, 1, 5, 0, 0, 0, 0, 1); #1;
      chk("young_stall", 32'(st_f), 1);
      chk("young_noadd", 32'(as_f == 2'd1), 0);
      tick(); #1;
      chk("young_stall2", 32'(st_f), 0);
      chk("young_srca", 32'(as_f), 2);
      chk("young_opa", a_f, E2);

      // hold freezes the scoreboard for 4 cycles
      do_reset();
      set_id(1, 0, 0, 0, 0, 1, 4, 2); tick();
      set_id(1, 0, 0, 1, 4, 1, 8, 1); hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1 chk("hold_stall", 32'(st_f), 1);
         tick();
      end
      chk("hold_scnt", sc_f, 0);
      hold = 1'b0; #1;
      chk("unhold_stall", 32'(st_f), 1);
      tick(); #1;
      chk("unhold_stall2", 32'(st_f), 0);
      chk("unhold_srcb", 32'(bs_f), 2);
      chk("unhold_scnt", sc_f, 1);

      // writes to r0 never match
      do_reset();
      set_id(1, 0, 0, 0, 0, 1, 0, 2); tick();
      set_id(1, 1, 0, 1, 0, 0, 0, 1); #1;
      chk("r0_stall", 32'(st_f), 0);
      chk("r0_srca", 32'(as_f), 0);

      // stall-only mode: ADD dependency stalls 3 cycles
      do_reset();
      set_id(1, 0, 0, 0, 0, 1, 3, 1); tick();
      set_id(1, 1, 3, 0, 0, 1, 7, 1);
      for (int i = 0; i < 3; i++) begin
         #1 chk("nf_add_stall", 32'(st_n), 1);
         chk("nf_add_src", 32'(as_n), 0);
         tick();
      end
      #1;
      chk("nf_add_go", 32'(st_n), 0);
      chk("nf_add_opa", a_n, RS);
      chk("nf_add_scnt", sc_n, 3);

      // stall-only mode: LW dependency stalls 3 cycles
      do_reset();
      set_id(1, 0, 0, 0, 0, 1, 4, 2); tick();
      set_id(1, 0, 0, 1, 4, 1, 8, 1);
      for (int i = 0; i < 3; i++) begin
         #1 chk("nf_lw_stall", 32'(st_n), 1);
         chk("nf_lw_src", 32'(bs_n), 0);
         tick();
      end
      #1;
      chk("nf_lw_go", 32'(st_n), 0);
      chk("nf_lw_opb", b_n, RT);
      chk("nf_fcnt", fc_n, 0);

      // flush kills entries 1..FLUSH_N
      do_reset();
      set_id(1, 0, 0, 0, 0, 1, 6, 2); tick();
      set_id(1, 0, 0, 1, 6, 1, 9, 1); flush = 1'b1; #1;
      chk("fl_stall_pre", 32'(st_2), 1);
      tick(); flush = 1'b0; #1;
      chk("fl2_stall", 32'(st_2), 0);
      chk("fl2_srcb", 32'(bs_2), 0);
      chk("fl2_opb", b_2, RT);
      chk("fl2_scnt", sc_2, 0);
      chk("fl1_srcb", 32'(bs_f), 2);

      // async reset drops a live stall at once
      do_reset();
      set_id(1, 0, 0, 0, 0, 1, 4, 2); tick();
      set_id(1, 0, 0, 1, 4, 1, 8, 1); #1;
      chk("ar_stall_pre", 32'(st_f), 1);
      rst = 1'b1; #1;
      chk("ar_stall", 32'(st_f), 0);
      rst = 1'b0;

      // stall counter saturates
      do_reset();
      set_id(1, 0, 0, 0, 0, 1, 3, 1); tick();
      set_id(1, 1, 3, 0, 0, 1, 7, 1);
      force u_nf.stall_cnt_q = 32'hFFFF_FFFE;
      #1 release u_nf.stall_cnt_q;
      for (int i = 0; i < 3; i++) tick();
      #1;
      chk("sat_scnt", sc_n, 32'hFFFF_FFFF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
